// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: response-owner tags and BOOT/RUN state.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DAT  = 2'd1,
    TAG_INS  = 2'd2
  } tag_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A flush turns any pending fetch response into a dropped slot.
  function automatic tag_e squash_ins(input tag_e tag, input logic squash);
    return (squash && tag == TAG_INS) ? TAG_NONE : tag;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Response-owner shift register: one tag per issued access, flushable fetch tags.
module mem_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic squash,
  input  tag_e tag_in,
  output tag_e tag_out
);

  tag_e tag_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= squash_ins(tag_in, squash);
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= squash_ins(tag_pipe[i-1], squash);
    end
  end

  assign tag_out = tag_pipe[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for loader, core data and core fetch; owns BOOT->RUN and
// routes read data back to whichever port issued the read.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOAD_LATENCY  = 1,
  parameter int ACTUAL_ADDR_W = 13,
  parameter int DATA_W        = 64,
  parameter int WE_W          = 8,
  parameter int MAX_STARVE    = 4,
  parameter int BOOT_SKIP     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ldr_req,
  input  logic [ACTUAL_ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0]        ldr_wdata,
  input  logic                     ldr_done,
  output logic                     ldr_gnt,
  input  logic                     dat_req,
  input  logic [ACTUAL_ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0]        dat_wdata,
  input  logic [WE_W-1:0]          dat_we,
  output logic                     dat_gnt,
  output logic                     dat_rvalid,
  output logic [DATA_W-1:0]        dat_rdata,
  input  logic                     ins_req,
  input  logic [ACTUAL_ADDR_W-1:0] ins_addr,
  input  logic                     ins_flush,
  output logic                     ins_gnt,
  output logic                     ins_rvalid,
  output logic [DATA_W-1:0]        ins_rdata,
  output logic                     booting,
  output logic                     mem_en,
  output logic [ACTUAL_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [WE_W-1:0]          mem_we,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  starve_cnt;
  logic              force_ins;
  tag_e              push_tag, tag_out;
  logic [DATA_W-1:0] dat_hold, ins_hold;

  always_ff @(posedge clk) begin
    if (rst) state <= (BOOT_SKIP != 0) ? ST_RUN : ST_BOOT;
    else     state <= state_nx;
  end

  // Grants already include the request, so a grant is an accept.
  always_comb begin
    state_nx  = state;
    ldr_gnt   = 1'b0;
    dat_gnt   = 1'b0;
    ins_gnt   = 1'b0;
    force_ins = ins_req && (starve_cnt == CNT_W'(MAX_STARVE));
    case (state)
      ST_BOOT: begin
        ldr_gnt = ldr_req;
        if (ldr_done) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (force_ins)    ins_gnt = 1'b1;
        else if (dat_req) dat_gnt = 1'b1;
        else              ins_gnt = ins_req;
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                     starve_cnt <= '0;
    else if (ins_req && !ins_gnt) begin
      if (starve_cnt != CNT_W'(MAX_STARVE)) starve_cnt <= starve_cnt + 1'b1;
    end else                     starve_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= '0;
    end else begin
      mem_en <= ldr_gnt | dat_gnt | ins_gnt;
      mem_we <= '0;
      if (ldr_gnt) begin
        mem_addr  <= ldr_addr;
        mem_wdata <= ldr_wdata;
        mem_we    <= '1;
      end else if (dat_gnt) begin
        mem_addr  <= dat_addr;
        mem_wdata <= dat_wdata;
        mem_we    <= dat_we;
      end else if (ins_gnt) begin
        mem_addr  <= ins_addr;
      end
    end
  end

  always_comb begin
    push_tag = TAG_NONE;
    if (dat_gnt && dat_we == '0) push_tag = TAG_DAT;
    else if (ins_gnt)            push_tag = TAG_INS;
  end

  // One extra stage covers the cycle the access spends on the mem_* bus.
  mem_tag_pipe #(.DEPTH(LOAD_LATENCY + 1)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .squash  (ins_flush),
    .tag_in  (push_tag),
    .tag_out (tag_out)
  );

  assign dat_rvalid = (tag_out == TAG_DAT);
  assign ins_rvalid = (tag_out == TAG_INS);
  assign dat_rdata  = dat_rvalid ? mem_rdata : dat_hold;
  assign ins_rdata  = ins_rvalid ? mem_rdata : ins_hold;
  assign booting    = (state == ST_BOOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_hold <= '0;
      ins_hold <= '0;
    end else begin
      if (dat_rvalid) dat_hold <= mem_rdata;
      if (ins_rvalid) ins_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: arbiter A (latency 1, boots) and arbiter B (latency 3, boot skipped),
// each with a small RAM model; read responses are checked against a scoreboard.
module tb_mem_port_arbiter;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_ldr_req, a_ldr_done, a_ldr_gnt;
  logic [12:0] a_ldr_addr;
  logic [63:0] a_ldr_wdata;
  logic        a_dat_req, a_dat_gnt, a_dat_rvalid;
  logic [12:0] a_dat_addr;
  logic [63:0] a_dat_wdata, a_dat_rdata;
  logic [7:0]  a_dat_we;
  logic        a_ins_req, a_ins_flush, a_ins_gnt, a_ins_rvalid;
  logic [12:0] a_ins_addr;
  logic [63:0] a_ins_rdata;
  logic        a_booting, a_mem_en;
  logic [12:0] a_mem_addr;
  logic [63:0] a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_mem_we;

  logic        b_ldr_req, b_ldr_done, b_ldr_gnt;
  logic [12:0] b_ldr_addr;
  logic [63:0] b_ldr_wdata;
  logic        b_dat_req, b_dat_gnt, b_dat_rvalid;
  logic [12:0] b_dat_addr;
  logic [63:0] b_dat_wdata, b_dat_rdata;
  logic [7:0]  b_dat_we;
  logic        b_ins_req, b_ins_flush, b_ins_gnt, b_ins_rvalid;
  logic [12:0] b_ins_addr;
  logic [63:0] b_ins_rdata;
  logic        b_booting, b_mem_en;
  logic [12:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_we;

  mem_port_arbiter #(.LOAD_LATENCY(1), .MAX_STARVE(4), .BOOT_SKIP(0)) dut_a (
    .clk(clk), .rst(rst),
    .ldr_req(a_ldr_req), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata), .ldr_done(a_ldr_done), .ldr_gnt(a_ldr_gnt),
    .dat_req(a_dat_req), .dat_addr(a_dat_addr), .dat_wdata(a_dat_wdata), .dat_we(a_dat_we), .dat_gnt(a_dat_gnt),
    .dat_rvalid(a_dat_rvalid), .dat_rdata(a_dat_rdata),
    .ins_req(a_ins_req), .ins_addr(a_ins_addr), .ins_flush(a_ins_flush), .ins_gnt(a_ins_gnt),
    .ins_rvalid(a_ins_rvalid), .ins_rdata(a_ins_rdata),
    .booting(a_booting), .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.LOAD_LATENCY(3), .MAX_STARVE(4), .BOOT_SKIP(1)) dut_b (
    .clk(clk), .rst(rst),
    .ldr_req(b_ldr_req), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata), .ldr_done(b_ldr_done), .ldr_gnt(b_ldr_gnt),
    .dat_req(b_dat_req), .dat_addr(b_dat_addr), .dat_wdata(b_dat_wdata), .dat_we(b_dat_we), .dat_gnt(b_dat_gnt),
    .dat_rvalid(b_dat_rvalid), .dat_rdata(b_dat_rdata),
    .ins_req(b_ins_req), .ins_addr(b_ins_addr), .ins_flush(b_ins_flush), .ins_gnt(b_ins_gnt),
    .ins_rvalid(b_ins_rvalid), .ins_rdata(b_ins_rdata),
    .booting(b_booting), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  // RAM models: A returns data one cycle after mem_en, B three cycles after.
  logic [63:0] a_ram [32];
  logic [63:0] b_ram [32];
  logic [63:0] b_rd0, b_rd1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) a_ram[i] <= '0;
      a_mem_rdata <= '0;
    end else if (a_mem_en) begin
      for (int k = 0; k < 8; k++)
        if (a_mem_we[k]) a_ram[a_mem_addr[4:0]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
      a_mem_rdata <= a_ram[a_mem_addr[4:0]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) b_ram[i] <= '0;
      b_rd0 <= '0; b_rd1 <= '0; b_mem_rdata <= '0;
    end else begin
      if (b_mem_en) begin
        for (int k = 0; k < 8; k++)
          if (b_mem_we[k]) b_ram[b_mem_addr[4:0]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
        b_rd0 <= b_ram[b_mem_addr[4:0]];
      end
      b_rd1       <= b_rd0;
      b_mem_rdata <= b_rd1;
    end
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t qad[$], qai[$], qbi[$];
  logic [63:0] pat [3];

  function automatic exp_t mk(input int due, input logic [63:0] data);
    exp_t e;
    e.due  = due;
    e.data = data;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample after the edge and settle scoreboard responses due now.
  task automatic tick();
    logic ev;
    @(posedge clk);
    #2;
    cyc++;
    ev = (qad.size() > 0) && (qad[0].due == cyc);
    chk("a_dat_rvalid", a_dat_rvalid, ev);
    if (ev) begin chk("a_dat_rdata", a_dat_rdata, qad[0].data); void'(qad.pop_front()); end
    ev = (qai.size() > 0) && (qai[0].due == cyc);
    chk("a_ins_rvalid", a_ins_rvalid, ev);
    if (ev) begin chk("a_ins_rdata", a_ins_rdata, qai[0].data); void'(qai.pop_front()); end
    ev = (qbi.size() > 0) && (qbi[0].due == cyc);
    chk("b_ins_rvalid", b_ins_rvalid, ev);
    if (ev) begin chk("b_ins_rdata", b_ins_rdata, qbi[0].data); void'(qbi.pop_front()); end
    chk("b_dat_rvalid", b_dat_rvalid, 1'b0);
  endtask

  task automatic idle_a();
    a_ldr_req = 0; a_ldr_done = 0; a_ldr_addr = '0; a_ldr_wdata = '0;
    a_dat_req = 0; a_dat_addr = '0; a_dat_wdata = '0; a_dat_we = '0;
    a_ins_req = 0; a_ins_addr = '0; a_ins_flush = 0;
  endtask

  task automatic idle_b();
    b_ldr_req = 0; b_ldr_done = 0; b_ldr_addr = '0; b_ldr_wdata = '0;
    b_dat_req = 0; b_dat_addr = '0; b_dat_wdata = '0; b_dat_we = '0;
    b_ins_req = 0; b_ins_addr = '0; b_ins_flush = 0;
  endtask

  initial begin
    pat[0] = 64'hAAAA_0000_AAAA_0000;
    pat[1] = 64'hBBBB_1111_BBBB_1111;
    pat[2] = 64'hCCCC_2222_CCCC_2222;
    rst = 1'b1;
    idle_a();
    idle_b();
    tick();
    tick();
    chk("rst_a_booting", a_booting, 1'b1);
    chk("rst_a_mem_en", a_mem_en, 1'b0);
    chk("rst_a_mem_we", a_mem_we, 8'h00);
    chk("rst_b_booting", b_booting, 1'b0);
    chk("rst_b_ldr_gnt", b_ldr_gnt, 1'b0);
    chk("rst_b_dat_rdata", b_dat_rdata, 64'h0);
    rst = 1'b0;

    // BOOT: loader writes 0..2; core requests held high but never granted
    a_dat_req = 1; a_dat_addr = 13'd7; a_ins_req = 1; a_ins_addr = 13'd7;
    for (int i = 0; i < 3; i++) begin
      a_ldr_req = 1; a_ldr_addr = 13'(i); a_ldr_wdata = pat[i]; a_ldr_done = (i == 2);
      #1;
      chk("boot_ldr_gnt", a_ldr_gnt, 1'b1);
      chk("boot_dat_gnt", a_dat_gnt, 1'b0);
      chk("boot_ins_gnt", a_ins_gnt, 1'b0);
      tick();
      chk("boot_mem_en", a_mem_en, 1'b1);
      chk("boot_mem_we", a_mem_we, 8'hFF);
      chk("boot_mem_addr", a_mem_addr, 64'(i));
      chk("boot_mem_wdata", a_mem_wdata, pat[i]);
    end
    idle_a();
    chk("run_booting", a_booting, 1'b0);
    tick();

    // RUN: data read of addr 1; loader ignored
    a_ldr_req = 1; a_dat_req = 1; a_dat_we = 8'h00; a_dat_addr = 13'd1;
    #1;
    chk("run_ldr_gnt", a_ldr_gnt, 1'b0);
    chk("run_dat_gnt", a_dat_gnt, 1'b1);
    qad.push_back(mk(cyc + 2, pat[1]));
    tick();
    idle_a();
    chk("rd_mem_en", a_mem_en, 1'b1);
    chk("rd_mem_addr", a_mem_addr, 64'd1);
    chk("rd_mem_we", a_mem_we, 8'h00);
    tick();
    tick();

    // Starvation: fetch forced on the 5th and 10th cycle of contention
    a_dat_req = 1; a_dat_addr = 13'd0; a_ins_req = 1; a_ins_addr = 13'd2;
    for (int k = 0; k < 10; k++) begin
      logic want_ins;
      want_ins = (k == 4) || (k == 9);
      #1;
      chk("starve_ins_gnt", a_ins_gnt, want_ins);
      chk("starve_dat_gnt", a_dat_gnt, !want_ins);
      if (want_ins) qai.push_back(mk(cyc + 2, pat[2]));
      else          qad.push_back(mk(cyc + 2, pat[0]));
      tick();
    end
    idle_a();
    tick();
    tick();

    // Partial store: full word, then low four bytes, then read back
    a_dat_req = 1; a_dat_addr = 13'd5; a_dat_we = 8'hFF; a_dat_wdata = 64'hC0FFEE11_22334455;
    #1;
    chk("st_full_gnt", a_dat_gnt, 1'b1);
    tick();
    a_dat_we = 8'h0F; a_dat_wdata = 64'hAAAAAAAA_BBBBBBBB;
    #1;
    chk("st_part_gnt", a_dat_gnt, 1'b1);
    tick();
    chk("st_part_mem_we", a_mem_we, 8'h0F);
    a_dat_we = 8'h00;
    qad.push_back(mk(cyc + 2, 64'hC0FFEE11_BBBBBBBB));
    tick();
    idle_a();
    tick();
    tick();

    // B: seed addr 3, fetch then flush (dropped), fetch after flush returns at +4
    b_dat_req = 1; b_dat_addr = 13'd3; b_dat_we = 8'hFF; b_dat_wdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("b_st_gnt", b_dat_gnt, 1'b1);
    tick();
    idle_b();
    b_ins_req = 1; b_ins_addr = 13'd3;
    #1;
    chk("b_fetch_gnt", b_ins_gnt, 1'b1);
    tick();
    b_ins_req = 0; b_ins_flush = 1;
    tick();
    b_ins_flush = 0; b_ins_req = 1;
    qbi.push_back(mk(cyc + 4, 64'h0123_4567_89AB_CDEF));
    tick();
    b_ins_req = 0;
    repeat (5) tick();
    // fetch accepted in the flush cycle itself is dropped too
    b_ins_req = 1; b_ins_flush = 1;
    tick();
    idle_b();
    repeat (5) tick();

    // Reset with two reads in flight: nothing comes back
    a_dat_req = 1; a_dat_addr = 13'd1;
    tick();
    a_dat_addr = 13'd2; rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_a();
    chk("rst2_booting", a_booting, 1'b1);
    chk("rst2_mem_en", a_mem_en, 1'b0);
    chk("rst2_mem_we", a_mem_we, 8'h00);
    chk("rst2_mem_addr", a_mem_addr, 64'h0);
    chk("rst2_mem_wdata", a_mem_wdata, 64'h0);
    chk("rst2_dat_rdata", a_dat_rdata, 64'h0);
    chk("rst2_ins_rdata", a_ins_rdata, 64'h0);
    repeat (4) tick();

    chk("scoreboard_drained", 64'(qad.size() + qai.size() + qbi.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
